pc8001_ps2_matrix: RTL and testbench
====================================

// Module: pc8001_ps2_matrix
// PURPOSE
//   Consumer side of the hps_io ps2_key event stream.
//   Each toggle event is decoded, and the PC-8001 keyboard matrix is maintained from it.
//   The matrix is 10 rows x 8 columns and active-low.
//   The CPU I/O decode (ports 00h-09h) reads a row through row_sel and row_data.
//   The block replaces the unused physical PS/2 pins of the pc8001m core.
// PARAMETERS
//   NUM_ROWS  10  number of implemented matrix rows; row_sel >= NUM_ROWS reads 8'hFF
// PORTS
//   clk_sys    in   1   system clock; all logic is on this clock
//   reset      in   1   asynchronous, active-high reset
//   ps2_key    in   11  [10] toggle, [9] pressed, [8] extended (E0), [7:0] set-2 scancode
//   all_up     in   1   1-cycle pulse: release every key (OSD open, core download)
//   row_sel    in   4   matrix row requested by the CPU port decode
//   row_data   out  8   selected row, active-low (0 = key down), registered
//   key_event  out  1   1-cycle pulse when a mapped key changes the matrix
// BEHAVIOUR
// - Reset state: matrix all released; row_data=8'hFF; key_event=0; shift/ctrl flags=0; primed=0.
// - Priming: on the first clk_sys edge after reset deasserts:
//     * tog_q <= ps2_key[10] and primed <= 1;
//     * no event is generated, so a stale toggle level never produces a phantom key.
// - Stage 0 (S0, edge E0): when primed and ps2_key[10] != tog_q:
//     * capture {pressed, ext, code} into s1 and set s1_v;
//     * update tog_q.
// - Stage 1 (S1, edge E1): the case-table lookup of {ext, code} registers {map_v, row[3:0], col[2:0], kind} into s2.
//     * kind is one of NORMAL, LSHIFT, RSHIFT, LCTRL, RCTRL.
// - Stage 2 (S2, edge E2):
//     * NORMAL: if map_v, matrix[row][col] <= pressed and key_event=1 for this cycle.
//     * Shift: the LSHIFT/RSHIFT flags are updated; matrix[8][6] = lshift|rshift.
//     * Ctrl: the LCTRL/RCTRL flags are updated; matrix[8][7] = lctrl|rctrl.
//     * key_event also pulses for shift and ctrl kinds.
//     * map_v=0 (unmapped code): no change and no pulse.
// - row_data <= ~matrix[row_sel] every cycle (8'hFF if row_sel >= NUM_ROWS).
//   A key change is visible on row_data after edge E3.
//   Total latency is 3 edges after E0.
// - Back-to-back events:
//     * The pipeline accepts a new toggle every cycle; there is no stall and no loss.
//     * An event in S2 and the next event in S1 are independent.
//     * The last write to a given bit wins.
// - Repeated make codes (typematic) rewrite the same value.
//   They still pulse key_event; the CPU sees the key held, not re-pressed.
// - all_up:
//     * on the next edge the matrix and all shift/ctrl flags clear;
//     * s1_v and s2 valid are also cleared, so all_up wins over an event in flight;
//     * tog_q is kept, so no event is replayed.
// - Reset mid-operation: everything is cleared asynchronously and primed drops, so the pipeline must re-prime.
// - Map excerpt (set-2, E=extended):
//     * 'A' 1C -> r2c1; 'H' 33 -> r3c0; '0' 45 -> r6c0; Enter 5A -> r1c7;
//     * Space 29 -> r9c6; Esc 76 -> r9c7; F1 05 -> r9c1; Pause/F12 07 -> r9c0 (STOP);
//     * Up E75 -> r8c1; Right E74 -> r8c2; BkSp 66 -> r8c3; LAlt 11 -> r8c4 (GRPH); RAlt E11 -> r8c5 (KANA);
//     * LShift 12 and RShift 59 -> r8c6; LCtrl 14 and RCtrl E14 -> r8c7.
// - The remaining keys follow the PC-8001 matrix chart.
// - Keys with no PC-8001 equivalent are unmapped.
// TESTING
// 1. Reset with ps2_key[10]=1 held, release, no toggle for 20 cycles:
//    -> key_event never pulses; row_data reads 8'hFF for row_sel 0..9.
// 2. 'A' make {tog flip, pressed=1, 0x1C}, row_sel=2:
//    -> key_event pulses 2 edges after the toggle is sampled; row_data=8'hFD after the 3rd edge.
//    Then the break code -> row_data=8'hFF.
// 3. LShift make, RShift make, LShift break, row_sel=8:
//    -> row_data=8'hBF after each step; after the RShift break -> 8'hFF.
// 4. Unmapped code 0x0E make: -> no key_event; all rows remain 8'hFF.
//    Then row_sel=4'hC -> 8'hFF.
// 5. Enter make, then all_up pulsed on the cycle the event sits in S2:
//    -> row 1 stays 8'hFF and key_event stays 0.
//    A subsequent Enter make -> row 1 = 8'h7F.
// 6. Two toggles on consecutive cycles ('H' make, then '0' make):
//    -> after the pipeline drains, row 3 = 8'hFE and row 6 = 8'hFE; two key_event pulses.

Source files
------------

// File: rtl/pc8001_ps2_matrix.sv
// Decodes hps_io ps2_key toggle events into the active-low PC-8001 keyboard matrix.
// Three-edge pipeline: capture, map lookup, matrix update; row_data is registered.
module pc8001_ps2_matrix #(
    parameter int NUM_ROWS = 10
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [10:0] ps2_key,
    input  logic        all_up,
    input  logic [3:0]  row_sel,
    output logic [7:0]  row_data,
    output logic        key_event
);
    typedef enum logic [2:0] {K_NORMAL, K_LSHIFT, K_RSHIFT, K_LCTRL, K_RCTRL} kind_t;

    localparam logic [4:0] NROWS = 5'(NUM_ROWS);

    logic             primed, tog_q;
    logic             s1_v, s1_pressed;
    logic [8:0]       s1_key;
    logic             lk_v;
    logic [6:0]       lk_rc;
    kind_t            lk_kind;
    logic             s2_v, s2_pressed;
    logic [6:0]       s2_rc;
    kind_t            s2_kind;
    logic             lshift, rshift, lctrl, rctrl;
    logic [15:0][7:0] key_down;

    function automatic logic [6:0] rc(input int r, input int c);
        return 7'(r * 8 + c);
    endfunction

    // {ext, code} -> {row, col}; row in rc[6:3], column in rc[2:0]
    always_comb begin
        lk_v    = 1'b1;
        lk_rc   = '0;
        lk_kind = K_NORMAL;
        case (s1_key)
            9'h070: lk_rc = rc(0,0);  9'h069: lk_rc = rc(0,1);  9'h072: lk_rc = rc(0,2);  9'h07A: lk_rc = rc(0,3);
            9'h06B: lk_rc = rc(0,4);  9'h073: lk_rc = rc(0,5);  9'h074: lk_rc = rc(0,6);  9'h06C: lk_rc = rc(0,7);
            9'h075: lk_rc = rc(1,0);  9'h07D: lk_rc = rc(1,1);  9'h07C: lk_rc = rc(1,2);  9'h079: lk_rc = rc(1,3);
            9'h071: lk_rc = rc(1,6);  9'h05A: lk_rc = rc(1,7);  9'h15A: lk_rc = rc(1,7);
            9'h054: lk_rc = rc(2,0);  9'h01C: lk_rc = rc(2,1);  9'h032: lk_rc = rc(2,2);  9'h021: lk_rc = rc(2,3);
            9'h023: lk_rc = rc(2,4);  9'h024: lk_rc = rc(2,5);  9'h02B: lk_rc = rc(2,6);  9'h034: lk_rc = rc(2,7);
            9'h033: lk_rc = rc(3,0);  9'h043: lk_rc = rc(3,1);  9'h03B: lk_rc = rc(3,2);  9'h042: lk_rc = rc(3,3);
            9'h04B: lk_rc = rc(3,4);  9'h03A: lk_rc = rc(3,5);  9'h031: lk_rc = rc(3,6);  9'h044: lk_rc = rc(3,7);
            9'h04D: lk_rc = rc(4,0);  9'h015: lk_rc = rc(4,1);  9'h02D: lk_rc = rc(4,2);  9'h01B: lk_rc = rc(4,3);
            9'h02C: lk_rc = rc(4,4);  9'h03C: lk_rc = rc(4,5);  9'h02A: lk_rc = rc(4,6);  9'h01D: lk_rc = rc(4,7);
            9'h022: lk_rc = rc(5,0);  9'h035: lk_rc = rc(5,1);  9'h01A: lk_rc = rc(5,2);  9'h05B: lk_rc = rc(5,3);
            9'h06A: lk_rc = rc(5,4);  9'h05D: lk_rc = rc(5,5);  9'h055: lk_rc = rc(5,6);  9'h04E: lk_rc = rc(5,7);
            9'h045: lk_rc = rc(6,0);  9'h016: lk_rc = rc(6,1);  9'h01E: lk_rc = rc(6,2);  9'h026: lk_rc = rc(6,3);
            9'h025: lk_rc = rc(6,4);  9'h02E: lk_rc = rc(6,5);  9'h036: lk_rc = rc(6,6);  9'h03D: lk_rc = rc(6,7);
            9'h03E: lk_rc = rc(7,0);  9'h046: lk_rc = rc(7,1);  9'h052: lk_rc = rc(7,2);  9'h04C: lk_rc = rc(7,3);
            9'h041: lk_rc = rc(7,4);  9'h049: lk_rc = rc(7,5);  9'h04A: lk_rc = rc(7,6);  9'h051: lk_rc = rc(7,7);
            9'h16C: lk_rc = rc(8,0);  9'h175: lk_rc = rc(8,1);  9'h174: lk_rc = rc(8,2);  9'h066: lk_rc = rc(8,3);
            9'h171: lk_rc = rc(8,3);  9'h011: lk_rc = rc(8,4);  9'h111: lk_rc = rc(8,5);
            9'h007: lk_rc = rc(9,0);  9'h005: lk_rc = rc(9,1);  9'h006: lk_rc = rc(9,2);  9'h004: lk_rc = rc(9,3);
            9'h00C: lk_rc = rc(9,4);  9'h003: lk_rc = rc(9,5);  9'h029: lk_rc = rc(9,6);  9'h076: lk_rc = rc(9,7);
            9'h012: lk_kind = K_LSHIFT;
            9'h059: lk_kind = K_RSHIFT;
            9'h014: lk_kind = K_LCTRL;
            9'h114: lk_kind = K_RCTRL;
            default: lk_v = 1'b0;
        endcase
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            primed     <= 1'b0;
            tog_q      <= 1'b0;
            s1_v       <= 1'b0;
            s1_pressed <= 1'b0;
            s1_key     <= '0;
            s2_v       <= 1'b0;
            s2_pressed <= 1'b0;
            s2_rc      <= '0;
            s2_kind    <= K_NORMAL;
            lshift     <= 1'b0;
            rshift     <= 1'b0;
            lctrl      <= 1'b0;
            rctrl      <= 1'b0;
            key_down   <= '0;
            key_event  <= 1'b0;
            row_data   <= 8'hFF;
        end else begin
            key_event <= 1'b0;

            // First edge after reset only adopts the toggle level, so a stale level is not an event
            s1_v <= 1'b0;
            if (!primed) begin
                primed <= 1'b1;
                tog_q  <= ps2_key[10];
            end else if (ps2_key[10] != tog_q) begin
                tog_q      <= ps2_key[10];
                s1_v       <= 1'b1;
                s1_pressed <= ps2_key[9];
                s1_key     <= ps2_key[8:0];
            end

            s2_v       <= s1_v & lk_v;
            s2_pressed <= s1_pressed;
            s2_rc      <= lk_rc;
            s2_kind    <= lk_kind;

            if (s2_v) begin
                key_event <= 1'b1;
                case (s2_kind)
                    K_LSHIFT: begin lshift <= s2_pressed; key_down[8][6] <= s2_pressed | rshift; end
                    K_RSHIFT: begin rshift <= s2_pressed; key_down[8][6] <= s2_pressed | lshift; end
                    K_LCTRL:  begin lctrl  <= s2_pressed; key_down[8][7] <= s2_pressed | rctrl;  end
                    K_RCTRL:  begin rctrl  <= s2_pressed; key_down[8][7] <= s2_pressed | lctrl;  end
                    default:  key_down[s2_rc[6:3]][s2_rc[2:0]] <= s2_pressed;
                endcase
            end

            // all_up overrides anything in flight; tog_q is left alone so nothing replays
            if (all_up) begin
                s1_v      <= 1'b0;
                s2_v      <= 1'b0;
                lshift    <= 1'b0;
                rshift    <= 1'b0;
                lctrl     <= 1'b0;
                rctrl     <= 1'b0;
                key_down  <= '0;
                key_event <= 1'b0;
            end

            row_data <= ({1'b0, row_sel} < NROWS) ? ~key_down[row_sel] : 8'hFF;
        end
    end
endmodule

// File: tb/tb_pc8001_ps2_matrix.sv
// Directed plus randomized check of pc8001_ps2_matrix against a key-set model.
module tb_pc8001_ps2_matrix;
    logic        clk_sys = 1'b0;
    logic        reset;
    logic [10:0] ps2_key;
    logic        all_up;
    logic [3:0]  row_sel;
    logic [7:0]  row_data;
    logic        key_event;

    pc8001_ps2_matrix #(.NUM_ROWS(10)) dut (
        .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .all_up(all_up),
        .row_sel(row_sel), .row_data(row_data), .key_event(key_event)
    );

    always #5 clk_sys = ~clk_sys;

    int n_cmp = 0;
    int n_err = 0;
    int ev_cnt = 0;
    always @(negedge clk_sys) if (key_event === 1'b1) ev_cnt++;

    // model: which keys are down, modifier flags, expected number of key_event pulses
    bit [7:0] m_mat [10];
    bit       m_lsh, m_rsh, m_lct, m_rct;
    int       m_ev = 0;
    int       kmap [int];
    logic     tog;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic m_clear();
        for (int r = 0; r < 10; r++) m_mat[r] = 8'h00;
        m_lsh = 0; m_rsh = 0; m_lct = 0; m_rct = 0;
    endtask

    task automatic m_apply(input bit p, input bit [8:0] k);
        if (k == 9'h012 || k == 9'h059) begin
            if (k == 9'h012) m_lsh = p; else m_rsh = p;
            m_mat[8][6] = m_lsh | m_rsh;
            m_ev++;
        end else if (k == 9'h014 || k == 9'h114) begin
            if (k == 9'h014) m_lct = p; else m_rct = p;
            m_mat[8][7] = m_lct | m_rct;
            m_ev++;
        end else if (kmap.exists(int'(k))) begin
            m_mat[kmap[int'(k)] / 8][kmap[int'(k)] % 8] = p;
            m_ev++;
        end
    endtask

    // one event on ps2_key; the tick is the edge that samples it
    task automatic send(input bit p, input bit [8:0] k);
        tog = ~tog;
        ps2_key = {tog, p, k};
        m_apply(p, k);
        tick();
    endtask

    task automatic drain();
        repeat (3) tick();
    endtask

    task automatic check_all(input string tag);
        for (int r = 0; r < 10; r++) begin
            row_sel = 4'(r);
            tick();
            chk($sformatf("%s_row%0d", tag, r), {24'h0, row_data}, {24'h0, ~m_mat[r]});
        end
        chk({tag, "_events"}, ev_cnt, m_ev);
    endtask

    bit [8:0] pool [26] = '{9'h01C, 9'h033, 9'h045, 9'h05A, 9'h029, 9'h076, 9'h005, 9'h007,
                           9'h175, 9'h174, 9'h066, 9'h011, 9'h111, 9'h012, 9'h059, 9'h014,
                           9'h114, 9'h070, 9'h07D, 9'h17D, 9'h00E, 9'h058, 9'h11F, 9'h032,
                           9'h04D, 9'h022};

    initial begin
        int ev0;
        kmap[9'h01C] = 2*8+1; kmap[9'h033] = 3*8+0; kmap[9'h045] = 6*8+0; kmap[9'h05A] = 1*8+7;
        kmap[9'h029] = 9*8+6; kmap[9'h076] = 9*8+7; kmap[9'h005] = 9*8+1; kmap[9'h007] = 9*8+0;
        kmap[9'h175] = 8*8+1; kmap[9'h174] = 8*8+2; kmap[9'h066] = 8*8+3; kmap[9'h011] = 8*8+4;
        kmap[9'h111] = 8*8+5; kmap[9'h070] = 0*8+0; kmap[9'h07D] = 1*8+1; kmap[9'h032] = 2*8+2;
        kmap[9'h04D] = 4*8+0; kmap[9'h022] = 5*8+0;
        m_clear();

        // reset held with a high toggle level
        tog = 1'b1; ps2_key = {1'b1, 10'h0}; all_up = 0; row_sel = 0; reset = 1;
        repeat (3) tick();
        chk("reset_row_data", {24'h0, row_data}, 32'hFF);
        chk("reset_key_event", {31'h0, key_event}, 32'h0);
        reset = 0;
        repeat (20) tick();
        chk("prime_no_event", ev_cnt, 0);
        check_all("prime");

        // 'A' make with exact latency
        row_sel = 2;
        tog = ~tog; ps2_key = {tog, 1'b1, 9'h01C}; m_apply(1, 9'h01C);
        tick(); chk("a_ev_e0", {31'h0, key_event}, 0);
        tick(); chk("a_ev_e1", {31'h0, key_event}, 0);
        tick(); chk("a_ev_e2", {31'h0, key_event}, 1);
        chk("a_row_e2", {24'h0, row_data}, 32'hFF);
        tick(); chk("a_row_e3", {24'h0, row_data}, 32'hFD);
        chk("a_ev_e3", {31'h0, key_event}, 0);
        send(0, 9'h01C); drain();
        chk("a_break", {24'h0, row_data}, 32'hFF);

        // shift pair on row 8
        row_sel = 8;
        send(1, 9'h012); drain(); chk("lshift_make", {24'h0, row_data}, 32'hBF);
        send(1, 9'h059); drain(); chk("rshift_make", {24'h0, row_data}, 32'hBF);
        send(0, 9'h012); drain(); chk("lshift_break", {24'h0, row_data}, 32'hBF);
        send(0, 9'h059); drain(); chk("rshift_break", {24'h0, row_data}, 32'hFF);

        // unmapped code
        send(1, 9'h00E); drain();
        check_all("unmapped");
        row_sel = 4'hC; tick();
        chk("row_sel_C", {24'h0, row_data}, 32'hFF);
        row_sel = 4'hF; tick();
        chk("row_sel_F", {24'h0, row_data}, 32'hFF);

        // all_up lands on the edge that would commit Enter
        ev0 = ev_cnt;
        tog = ~tog; ps2_key = {tog, 1'b1, 9'h05A};
        tick(); tick();
        all_up = 1; tick(); all_up = 0;
        chk("allup_key_event", {31'h0, key_event}, 0);
        m_clear(); drain();
        chk("allup_no_pulse", ev_cnt, ev0);
        check_all("allup");
        send(1, 9'h05A); drain();
        row_sel = 1; tick();
        chk("enter_after_allup", {24'h0, row_data}, 32'h7F);

        // back-to-back events
        ev0 = ev_cnt;
        send(1, 9'h033); send(1, 9'h045); drain();
        chk("b2b_two_events", ev_cnt - ev0, 2);
        check_all("b2b");

        // random bursts, occasional all_up while idle
        for (int b = 0; b < 30; b++) begin
            int n;
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) send(1'($urandom_range(0, 1)), pool[$urandom_range(0, 25)]);
            drain();
            if ($urandom_range(0, 5) == 0) begin
                all_up = 1; tick(); all_up = 0; m_clear();
            end
            check_all($sformatf("rnd%0d", b));
        end

        // reset mid-operation, toggle flips while reset, must re-prime silently
        send(1, 9'h029); drain();
        reset = 1; #2;
        chk("midreset_row_data", {24'h0, row_data}, 32'hFF);
        tog = ~tog; ps2_key = {tog, 1'b1, 9'h01C};
        tick(); m_clear();
        ev0 = ev_cnt;
        reset = 0;
        repeat (5) tick();
        chk("reprime_no_event", ev_cnt, ev0);
        check_all("reprime");
        send(1, 9'h01C); drain();
        check_all("post_reset_a");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
